// File: rtl/div_operand_normalizer_pkg.sv
// ---------------------------------------------------------------------------
// div_operand_normalizer_pkg
// Shared definitions for the Goldschmidt divide front end:
//   - FSM state encoding (IDLE=0, NORM=1, ISSUE=2, WAIT=3, DONE=4)
//   - divider datapath width, exponent width, default watchdog limit
//   - helper that forms the signed rescale exponent from two shift amounts
// ---------------------------------------------------------------------------
package div_operand_normalizer_pkg;

  localparam int DIV_W              = 32;
  localparam int EXP_W              = 6;
  localparam int WAIT_LIMIT_DEFAULT = 16;
  localparam int WDOG_W             = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NORM  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Quotient rescale exponent: q(Q1.31) * 2^(sb - sa). Both shift amounts
  // are zero-extended before subtraction so the 6-bit result is a proper
  // two's complement value in -31..+31.
  function automatic logic [EXP_W-1:0] norm_exp(input logic [4:0] sb,
                                                input logic [4:0] sa);
    norm_exp = {1'b0, sb} - {1'b0, sa};
  endfunction

endpackage

// File: rtl/div_operand_normalizer_lzc32.sv
// ---------------------------------------------------------------------------
// lzc32
// Combinational 32-bit leading-zero counter.
// Ports:
//   data_i   in  32  value to scan
//   count_o  out 5   number of leading zeros (0..31); 0 when data_i is zero
//   zero_o   out 1   data_i is all zeros (count_o is then meaningless)
// ---------------------------------------------------------------------------
module lzc32 (
  input  logic [31:0] data_i,
  output logic [4:0]  count_o,
  output logic        zero_o
);

  // Priority scan from LSB upward so the highest set bit wins last.
  always_comb begin
    count_o = 5'd0;
    zero_o  = (data_i == 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) begin
        count_o = 5'(31 - i);
      end else begin
        count_o = count_o;
      end
    end
  end

endmodule

// File: rtl/div_operand_normalizer.sv
// ---------------------------------------------------------------------------
// div_operand_normalizer
// Front end of the Goldschmidt divide path. Captures an unsigned operand
// pair, normalises both into [0.5,1) Q0.32 by leading-zero shift, pulses
// div_start to the divider, waits (with watchdog) for div_ready and reports
// the exponent that rescales the quotient. Zero operands are resolved here
// and never reach the divider.
// Ports:
//   clk          in   1   clock, rising edge
//   clrn         in   1   asynchronous active-low reset
//   in_valid     in   1   operand pair valid
//   in_ready     out  1   operands accepted (high only in IDLE)
//   dividend     in   32  unsigned dividend
//   divisor      in   32  unsigned divisor
//   div_a        out  32  normalised dividend (MSB=1 when issued)
//   div_b        out  32  normalised divisor  (MSB=1 when issued)
//   div_start    out  1   one-cycle start pulse to divider
//   div_ready    in   1   divider result ready
//   res_valid    out  1   one-cycle pulse, result metadata valid
//   res_exp      out  6   signed exponent, quotient = q * 2^res_exp
//   res_zero     out  1   dividend was zero
//   res_dz       out  1   divisor was zero
//   res_timeout  out  1   divider did not answer within WAIT_LIMIT cycles
// WIDTH is fixed at 32 by the divider interface; WAIT_LIMIT is 8..255.
// ---------------------------------------------------------------------------
module div_operand_normalizer
  import div_operand_normalizer_pkg::*;
#(
  parameter int WIDTH      = DIV_W,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_start,
  input  logic             div_ready,
  output logic             res_valid,
  output logic [EXP_W-1:0] res_exp,
  output logic             res_zero,
  output logic             res_dz,
  output logic             res_timeout
);

  localparam logic [WDOG_W-1:0] WAIT_LIMIT_C = WDOG_W'(WAIT_LIMIT);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   div_a_q, div_a_d;
  logic [WIDTH-1:0]   div_b_q, div_b_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               zero_q, zero_d;
  logic               dz_q, dz_d;
  logic               to_q, to_d;
  logic               start_q, start_d;
  logic               valid_q, valid_d;
  logic               in_ready_q, in_ready_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;

  logic [4:0]         sa_s, sb_s;
  logic               a_zero_s, b_zero_s;

  lzc32 u_lzc_a (
    .data_i  (op_a_q),
    .count_o (sa_s),
    .zero_o  (a_zero_s)
  );

  lzc32 u_lzc_b (
    .data_i  (op_b_q),
    .count_o (sb_s),
    .zero_o  (b_zero_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    to_d    = to_q;
    wdog_d  = wdog_q;

    case (state_q)
      ST_IDLE: begin
        // in_ready_q gates acceptance so nothing is taken in the first
        // cycle after reset release, while in_ready still reads 0.
        if (in_valid && in_ready_q) begin
          op_a_d  = dividend;
          op_b_d  = divisor;
          zero_d  = 1'b0;
          dz_d    = 1'b0;
          to_d    = 1'b0;
          state_d = ST_NORM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_NORM: begin
        div_a_d = op_a_q << sa_s;
        div_b_d = op_b_q << sb_s;
        // Divide-by-zero outranks a zero dividend; neither path has a
        // meaningful exponent so it is reported as 0.
        if (b_zero_s) begin
          dz_d    = 1'b1;
          exp_d   = {EXP_W{1'b0}};
          state_d = ST_DONE;
        end else if (a_zero_s) begin
          zero_d  = 1'b1;
          exp_d   = {EXP_W{1'b0}};
          state_d = ST_DONE;
        end else begin
          exp_d   = norm_exp(sb_s, sa_s);
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wdog_d  = {WDOG_W{1'b0}};
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // div_ready is never looked at in ISSUE: the divider's stale ready
        // from the previous operation is only cleared by the start edge.
        if (div_ready) begin
          state_d = ST_DONE;
        end else if ((wdog_q + 8'd1) == WAIT_LIMIT_C) begin
          wdog_d  = wdog_q + 8'd1;
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          wdog_d  = wdog_q + 8'd1;
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes and in_ready are decoded from the next state so they appear
    // registered in the cycle the FSM occupies that state.
    start_d    = (state_d == ST_ISSUE);
    valid_d    = (state_d == ST_DONE);
    in_ready_d = (state_d == ST_IDLE);
  end

  // State, operand, result and watchdog registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      op_a_q     <= {WIDTH{1'b0}};
      op_b_q     <= {WIDTH{1'b0}};
      div_a_q    <= {WIDTH{1'b0}};
      div_b_q    <= {WIDTH{1'b0}};
      exp_q      <= {EXP_W{1'b0}};
      zero_q     <= 1'b0;
      dz_q       <= 1'b0;
      to_q       <= 1'b0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b0;
      wdog_q     <= {WDOG_W{1'b0}};
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      exp_q      <= exp_d;
      zero_q     <= zero_d;
      dz_q       <= dz_d;
      to_q       <= to_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      in_ready_q <= in_ready_d;
      wdog_q     <= wdog_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign div_start   = start_q;
  assign res_valid   = valid_q;
  assign res_exp     = exp_q;
  assign res_zero    = zero_q;
  assign res_dz      = dz_q;
  assign res_timeout = to_q;

endmodule
